// File: rtl/alu_pkg.sv
// Shared definitions for the alu_md execute-stage ALU: opcodes, mul/div FSM states
// and divide-by-zero result constants. The DIV state exists only when ALU_DIV_EN is defined.
package alu_pkg;

   localparam logic [4:0] OP_ADD   = 5'd1;
   localparam logic [4:0] OP_SUB   = 5'd2;
   localparam logic [4:0] OP_AND   = 5'd3;
   localparam logic [4:0] OP_OR    = 5'd4;
   localparam logic [4:0] OP_XOR   = 5'd5;
   localparam logic [4:0] OP_LUI   = 5'd6;
   localparam logic [4:0] OP_SLT   = 5'd7;
   localparam logic [4:0] OP_SLL   = 5'd8;
   localparam logic [4:0] OP_SRL   = 5'd9;
   localparam logic [4:0] OP_SRA   = 5'd10;
   localparam logic [4:0] OP_SLTU  = 5'd11;
   localparam logic [4:0] OP_MULT  = 5'd12;
   localparam logic [4:0] OP_MULTU = 5'd13;
   localparam logic [4:0] OP_DIV   = 5'd14;
   localparam logic [4:0] OP_DIVU  = 5'd15;
   localparam logic [4:0] OP_MFHI  = 5'd16;
   localparam logic [4:0] OP_MFLO  = 5'd17;

   // Divide by zero: lo is filled with this bit, hi keeps the dividend.
   localparam logic DIVZ_LO_BIT        = 1'b1;
   localparam logic DIVZ_HI_IS_DIVIDEND = 1'b1;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_MUL  = 2'd1,
`ifdef ALU_DIV_EN
      MD_DIV  = 2'd2,
`endif
      MD_FIX  = 2'd3
   } md_state_t;

endpackage

// File: rtl/alu_md_if.sv
// EX-stage bus between the pipeline (master) and alu_md (slave), including the
// mul/div stall handshake and the FSM state for observation.
interface alu_md_if
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   localparam int SHW = $clog2(WIDTH)
);
   logic             in_valid;
   logic             flush;
   logic [4:0]       alu_ctrl;
   logic [WIDTH-1:0] data1;
   logic [WIDTH-1:0] data2;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] alu_res;
   logic             zero;
   logic             busy;
   logic             md_done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   md_state_t        md_state;

   // Handshake: a mul/div is accepted only on a cycle with in_valid high and busy low;
   // while busy is high EX must stall, and md_done pulses for one cycle when hi/lo change.
   modport master (
      output in_valid, flush, alu_ctrl, data1, data2, shamt,
      input  alu_res, zero, busy, md_done, hi, lo, md_state
   );

   modport slave (
      input  in_valid, flush, alu_ctrl, data1, data2, shamt,
      output alu_res, zero, busy, md_done, hi, lo, md_state
   );
endinterface

// File: rtl/md_iter.sv
// Iterative multiply/divide core: radix-2 shift-add multiply, restoring divide,
// sign fix-up and the HI/LO registers. Divider present only with ALU_DIV_EN.
module md_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             flush,
   input  logic [4:0]       alu_ctrl,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   output logic             busy,
   output logic             md_done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output md_state_t        state
);

   md_state_t          state_q, state_d;
   logic [SHW-1:0]     cnt_q;
   logic [WIDTH-1:0]   opd_q;
   logic [2*WIDTH-1:0] acc_q;
   logic               neg_q;

   logic               is_mul, is_div, signed_op, start, last, sa, sb;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next, prod_fix;

   assign is_mul    = (alu_ctrl == OP_MULT) || (alu_ctrl == OP_MULTU);
   assign signed_op = (alu_ctrl == OP_MULT) || (alu_ctrl == OP_DIV);
`ifdef ALU_DIV_EN
   assign is_div    = (alu_ctrl == OP_DIV) || (alu_ctrl == OP_DIVU);
`else
   assign is_div    = 1'b0;
`endif
   assign start = in_valid && (is_mul || is_div) && (state_q == MD_IDLE) && !flush;
   assign last  = (cnt_q == SHW'(WIDTH-1));

   assign sa    = signed_op & data1[WIDTH-1];
   assign sb    = signed_op & data2[WIDTH-1];
   assign mag_a = sa ? -data1 : data1;
   assign mag_b = sb ? -data2 : data2;

   // Multiply: acc = {partial product, remaining multiplier bits}; opd holds |A|.
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
   assign prod_fix = neg_q ? -acc_q : acc_q;

`ifdef ALU_DIV_EN
   logic               neg_rem_q, is_div_q, div_zero_q;
   logic [WIDTH:0]     shifted;
   logic [WIDTH-1:0]   sub_lo, quo_fix, rem_fix;
   logic               ge;
   logic [2*WIDTH-1:0] div_next;

   // Divide: acc = {remainder, quotient/dividend}; opd holds |B|.
   assign shifted  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign ge       = shifted >= {1'b0, opd_q};
   assign sub_lo   = shifted[WIDTH-1:0] - opd_q;
   assign div_next = ge ? {sub_lo, acc_q[WIDTH-2:0], 1'b1}
                        : {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
   // With a zero divisor the remainder ends as |A|, so the sign fix restores the dividend.
   assign quo_fix  = div_zero_q ? {WIDTH{DIVZ_LO_BIT}}
                                : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
   assign rem_fix  = (neg_rem_q && DIVZ_HI_IS_DIVIDEND) ? -acc_q[2*WIDTH-1:WIDTH]
                                                        : acc_q[2*WIDTH-1:WIDTH];
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         MD_IDLE: begin
`ifdef ALU_DIV_EN
            if (start) state_d = is_div ? MD_DIV : MD_MUL;
`else
            if (start) state_d = MD_MUL;
`endif
         end
         MD_MUL:  if (last) state_d = MD_FIX;
`ifdef ALU_DIV_EN
         MD_DIV:  if (last) state_d = MD_FIX;
`endif
         MD_FIX:  state_d = MD_IDLE;
         default: state_d = MD_IDLE;
      endcase
      if (flush) state_d = MD_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
         opd_q   <= '0;
         acc_q   <= '0;
         neg_q   <= 1'b0;
         md_done <= 1'b0;
         hi      <= '0;
         lo      <= '0;
`ifdef ALU_DIV_EN
         neg_rem_q  <= 1'b0;
         is_div_q   <= 1'b0;
         div_zero_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         md_done <= 1'b0;
         if (start) begin
            cnt_q <= '0;
            opd_q <= is_div ? mag_b : mag_a;
            acc_q <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
            neg_q <= sa ^ sb;
`ifdef ALU_DIV_EN
            neg_rem_q  <= sa;
            is_div_q   <= is_div;
            div_zero_q <= (data2 == '0);
`endif
         end else if (state_q == MD_MUL) begin
            acc_q <= mul_next;
            cnt_q <= cnt_q + 1'b1;
`ifdef ALU_DIV_EN
         end else if (state_q == MD_DIV) begin
            acc_q <= div_next;
            cnt_q <= cnt_q + 1'b1;
`endif
         end else if ((state_q == MD_FIX) && !flush) begin
            md_done <= 1'b1;
`ifdef ALU_DIV_EN
            if (is_div_q) begin
               hi <= rem_fix;
               lo <= quo_fix;
            end else begin
               {hi, lo} <= prod_fix;
            end
`else
            {hi, lo} <= prod_fix;
`endif
         end
      end
   end

   assign busy  = (state_q != MD_IDLE);
   assign state = state_q;

endmodule

// File: rtl/alu_md.sv
// Execute-stage ALU: combinational result path plus MFHI/MFLO mux around md_iter.
// Build with ALU_DIV_EN defined to include DIV/DIVU.
module alu_md
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic       clk,
   input  logic       rst,
   alu_md_if.slave    bus
);

   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] md_hi, md_lo;

   md_iter #(.WIDTH(WIDTH)) u_md_iter (
      .clk      (clk),
      .rst      (rst),
      .in_valid (bus.in_valid),
      .flush    (bus.flush),
      .alu_ctrl (bus.alu_ctrl),
      .data1    (bus.data1),
      .data2    (bus.data2),
      .busy     (bus.busy),
      .md_done  (bus.md_done),
      .hi       (md_hi),
      .lo       (md_lo),
      .state    (bus.md_state)
   );

   // Shifts operate on rt (data2); mul/div codes and unknown codes read as zero.
   always_comb begin
      res = '0;
      case (bus.alu_ctrl)
         OP_ADD:  res = bus.data1 + bus.data2;
         OP_SUB:  res = bus.data1 - bus.data2;
         OP_AND:  res = bus.data1 & bus.data2;
         OP_OR:   res = bus.data1 | bus.data2;
         OP_XOR:  res = bus.data1 ^ bus.data2;
         OP_LUI:  res = {bus.data2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(bus.data1) < $signed(bus.data2))};
         OP_SLTU: res = {{(WIDTH-1){1'b0}}, (bus.data1 < bus.data2)};
         OP_SLL:  res = bus.data2 << bus.shamt;
         OP_SRL:  res = bus.data2 >> bus.shamt;
         OP_SRA:  res = $signed(bus.data2) >>> bus.shamt;
         OP_MFHI: res = md_hi;
         OP_MFLO: res = md_lo;
         default: res = '0;
      endcase
   end

   assign bus.alu_res = res;
   assign bus.zero    = (res == '0);
   assign bus.hi      = md_hi;
   assign bus.lo      = md_lo;

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: combinational ops, mul/div latency and results,
// flush, mid-operation reset and (without ALU_DIV_EN) the disabled divider.
module tb_alu_md;
   import alu_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_md_if #(.WIDTH(W)) bus ();
   alu_md #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;
   logic [W-1:0]   exp_q[$];
   logic [2*W-1:0] md_q[$];
   logic [2*W-1:0] last_hilo;

   typedef struct {
      logic [4:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [4:0]   sh;
      logic [W-1:0] r;
   } alu_case_t;

   typedef struct {
      logic [4:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } md_case_t;

   function automatic logic [2*W-1:0] md_model(input logic [4:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
      logic [2*W-1:0] res;
      longint sa, sbv, q, r;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      res = '0;
      case (op)
         OP_MULT:  res = sa * sbv;
         OP_MULTU: res = {32'b0, a} * {32'b0, b};
         OP_DIVU:  res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         OP_DIV: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else begin
               q = sa / sbv;
               r = sa % sbv;
               res = {r[31:0], q[31:0]};
            end
         end
         default: res = '0;
      endcase
      return res;
   endfunction

   task automatic idle_inputs();
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      bus.alu_ctrl = 5'd0;
      bus.data1    = '0;
      bus.data2    = '0;
      bus.shamt    = '0;
   endtask

   // Drives one accepted request; returns at cycle 1 (#1 after edge 0).
   task automatic start_md(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.alu_ctrl = op;
      bus.data1    = a;
      bus.data2    = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.alu_ctrl = 5'd0;
   endtask

   task automatic wait_done(output int busy_n, output int done_at);
      busy_n  = 0;
      done_at = 0;
      for (int k = 1; k <= 100; k++) begin
         if (bus.md_done === 1'b1) begin
            done_at = k;
            break;
         end
         if (bus.busy === 1'b1) busy_n++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      #12;
      checks++; if (bus.hi !== '0) begin errors++; $display("FAIL reset_hi got %h exp 0", bus.hi); end
      checks++; if (bus.lo !== '0) begin errors++; $display("FAIL reset_lo got %h exp 0", bus.lo); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      checks++; if (bus.md_done !== 1'b0) begin errors++; $display("FAIL reset_md_done got %b exp 0", bus.md_done); end
      checks++; if (bus.md_state !== MD_IDLE) begin errors++; $display("FAIL reset_state got %0d exp 0", bus.md_state); end
      checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b exp 1", bus.zero); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_alu();
      alu_case_t t[$];
      logic [W-1:0] e, ra, rb;
      t.push_back('{OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000});
      t.push_back('{OP_SUB,  32'd5,         32'd5,         5'd0,  32'h0000_0000});
      t.push_back('{OP_SRA,  32'h8000_0000, 32'h8000_0000, 5'd4,  32'hF800_0000});
      t.push_back('{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001});
      t.push_back('{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000});
      t.push_back('{OP_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000});
      t.push_back('{OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  32'h0000_0001});
      t.push_back('{OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000});
      t.push_back('{OP_OR,   32'hF0F0_F0F0, 32'h0F0F_0000, 5'd0,  32'hFFFF_F0F0});
      t.push_back('{OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0,  32'hF0F0_0F0F});
      t.push_back('{OP_LUI,  32'h0000_0000, 32'hABCD_1234, 5'd0,  32'h1234_0000});
      t.push_back('{OP_SLL,  32'h8000_0001, 32'h8000_0001, 5'd1,  32'h0000_0002});
      t.push_back('{OP_SRL,  32'h8000_0000, 32'h8000_0000, 5'd31, 32'h0000_0001});
      t.push_back('{OP_SRA,  32'h4000_0000, 32'h4000_0000, 5'd2,  32'h1000_0000});
      t.push_back('{OP_SUB,  32'h0000_0000, 32'h0000_0001, 5'd0,  32'hFFFF_FFFF});
      t.push_back('{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000});
      t.push_back('{OP_MULT, 32'h0000_0003, 32'h0000_0007, 5'd0,  32'h0000_0000});
      t.push_back('{5'd0,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'h0000_0000});
      t.push_back('{5'd18,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'h0000_0000});
      t.push_back('{5'd31,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'h0000_0000});
      for (int i = 0; i < 6; i++) begin
         ra = $urandom();
         rb = $urandom_range(0, 65535);
         t.push_back('{OP_ADD, ra, rb, 5'd0, ra + rb});
         t.push_back('{OP_SUB, ra, rb, 5'd0, ra - rb});
         t.push_back('{OP_XOR, ra, rb, 5'd0, ra ^ rb});
      end
      foreach (t[i]) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.alu_ctrl = t[i].op;
         bus.data1    = t[i].a;
         bus.data2    = t[i].b;
         bus.shamt    = t[i].sh;
         exp_q.push_back(t[i].r);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (bus.alu_res !== e) begin
            errors++;
            $display("FAIL alu_res op=%0d a=%h b=%h got %h exp %h", t[i].op, t[i].a, t[i].b, bus.alu_res, e);
         end
         checks++;
         if (bus.zero !== (e == '0)) begin
            errors++;
            $display("FAIL alu_zero op=%0d got %b exp %b", t[i].op, bus.zero, (e == '0));
         end
      end
      idle_inputs();
   endtask

   // Consecutive requests start in the md_done cycle, so this also covers back-to-back issue.
   task automatic test_muldiv();
      md_case_t c[$];
      logic [2*W-1:0] e;
      int bn, da;
      c.push_back('{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007});
      c.push_back('{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
      c.push_back('{OP_MULT,  32'h8000_0000, 32'h8000_0000});
      c.push_back('{OP_MULT,  32'h8000_0000, 32'hFFFF_FFFF});
      c.push_back('{OP_MULTU, 32'h0000_0000, 32'h0001_2345});
`ifdef ALU_DIV_EN
      c.push_back('{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002});
      c.push_back('{OP_DIVU,  32'd100,       32'h0000_0000});
      c.push_back('{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF});
      c.push_back('{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000});
      c.push_back('{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE});
      c.push_back('{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010});
      for (int i = 0; i < 3; i++) begin
         c.push_back('{OP_DIV,  $urandom(), 32'($urandom_range(1, 1000))});
         c.push_back('{OP_DIVU, $urandom(), $urandom()});
      end
`endif
      for (int i = 0; i < 4; i++) begin
         c.push_back('{OP_MULT,  $urandom(), $urandom()});
         c.push_back('{OP_MULTU, $urandom(), 32'($urandom_range(0, 5000))});
      end
      foreach (c[i]) begin
         md_q.push_back(md_model(c[i].op, c[i].a, c[i].b));
         start_md(c[i].op, c[i].a, c[i].b);
         wait_done(bn, da);
         e = md_q.pop_front();
         checks++;
         if (da !== W + 2) begin errors++; $display("FAIL md_latency op=%0d got %0d exp %0d", c[i].op, da, W + 2); end
         checks++;
         if (bn !== W + 1) begin errors++; $display("FAIL md_busy_cycles op=%0d got %0d exp %0d", c[i].op, bn, W + 1); end
         checks++;
         if (bus.busy !== 1'b0) begin errors++; $display("FAIL md_busy_at_done got %b exp 0", bus.busy); end
         checks++;
         if ({bus.hi, bus.lo} !== e) begin
            errors++;
            $display("FAIL md_hilo op=%0d a=%h b=%h got %h_%h exp %h_%h", c[i].op, c[i].a, c[i].b,
                     bus.hi, bus.lo, e[63:32], e[31:0]);
         end
         bus.alu_ctrl = OP_MFHI;
         #1;
         checks++;
         if (bus.alu_res !== e[63:32]) begin errors++; $display("FAIL mfhi got %h exp %h", bus.alu_res, e[63:32]); end
         bus.alu_ctrl = OP_MFLO;
         #1;
         checks++;
         if (bus.alu_res !== e[31:0]) begin errors++; $display("FAIL mflo got %h exp %h", bus.alu_res, e[31:0]); end
         bus.alu_ctrl = 5'd0;
         last_hilo = e;
      end
   endtask

   task automatic test_flush();
      logic [2*W-1:0] e;
      int bn, da;
      bit seen;
      md_q.push_back(md_model(OP_MULTU, 32'h1234_5678, 32'h0000_0100));
      start_md(OP_MULTU, 32'h1234_5678, 32'h0000_0100);
      wait_done(bn, da);
      e = md_q.pop_front();
      checks++;
      if ({bus.hi, bus.lo} !== e || da !== W + 2) begin
         errors++;
         $display("FAIL flush_prior got %h_%h at %0d exp %h_%h at %0d", bus.hi, bus.lo, da, e[63:32], e[31:0], W + 2);
      end
      last_hilo = e;
      start_md(OP_MULT, 32'd3, 32'd5);
      for (int k = 1; k < 10; k++) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL flush_busy_c10 got %b exp 1", bus.busy); end
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy_next got %b exp 0", bus.busy); end
      checks++;
      if (bus.md_state !== MD_IDLE) begin errors++; $display("FAIL flush_state got %0d exp 0", bus.md_state); end
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (bus.md_done === 1'b1) seen = 1'b1;
         @(posedge clk);
         #1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL flush_md_done got 1 exp 0"); end
      checks++;
      if ({bus.hi, bus.lo} !== last_hilo) begin
         errors++;
         $display("FAIL flush_hilo got %h_%h exp %h_%h", bus.hi, bus.lo, last_hilo[63:32], last_hilo[31:0]);
      end
      // Flush beats a start in the same cycle.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.alu_ctrl = OP_MULT;
      bus.data1    = 32'd9;
      bus.data2    = 32'd9;
      bus.flush    = 1'b1;
      @(posedge clk);
      #1;
      idle_inputs();
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_vs_start busy got %b exp 0", bus.busy); end
   endtask

   task automatic test_reset_mid();
      logic [2*W-1:0] e;
      int bn, da;
`ifdef ALU_DIV_EN
      start_md(OP_DIV, 32'd100, 32'd7);
`else
      start_md(OP_MULT, 32'd100, 32'd7);
`endif
      for (int k = 1; k < 6; k++) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b exp 1", bus.busy); end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", bus.busy); end
      checks++;
      if ({bus.hi, bus.lo} !== '0) begin errors++; $display("FAIL rstmid_hilo got %h_%h exp 0_0", bus.hi, bus.lo); end
      @(negedge clk);
      rst = 1'b0;
      md_q.push_back(64'd6);
      start_md(OP_MULTU, 32'd2, 32'd3);
      wait_done(bn, da);
      e = md_q.pop_front();
      checks++;
      if ({bus.hi, bus.lo} !== e || da !== W + 2) begin
         errors++;
         $display("FAIL rstmid_multu got %h_%h at %0d exp %h_%h at %0d", bus.hi, bus.lo, da, e[63:32], e[31:0], W + 2);
      end
      last_hilo = e;
   endtask

`ifndef ALU_DIV_EN
   task automatic test_div_disabled();
      bit seen;
      for (int j = 0; j < 2; j++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.alu_ctrl = (j == 0) ? OP_DIV : OP_DIVU;
         bus.data1    = 32'd10;
         bus.data2    = 32'd2;
         #1;
         checks++;
         if (bus.alu_res !== '0) begin errors++; $display("FAIL nodiv_res got %h exp 0", bus.alu_res); end
         @(posedge clk);
         #1;
         idle_inputs();
         seen = 1'b0;
         for (int k = 0; k < 6; k++) begin
            if (bus.busy !== 1'b0 || bus.md_done !== 1'b0) seen = 1'b1;
            @(posedge clk);
            #1;
         end
         checks++;
         if (seen !== 1'b0) begin errors++; $display("FAIL nodiv_busy got activity exp none"); end
         checks++;
         if ({bus.hi, bus.lo} !== last_hilo) begin
            errors++;
            $display("FAIL nodiv_hilo got %h_%h exp %h_%h", bus.hi, bus.lo, last_hilo[63:32], last_hilo[31:0]);
         end
      end
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      last_hilo = '0;
      test_reset();
      test_alu();
      test_muldiv();
      test_flush();
      test_reset_mid();
`ifndef ALU_DIV_EN
      test_div_disabled();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
